// File: rtl/lcd_timing_pipe.sv
// Parameterised LCD scan generator: issues per-pixel requests (coordinates and
// sprite-window hit/address) and re-aligns HSYNC/VSYNC/DEN to the returned data.
module lcd_timing_pipe #(
  parameter int                 H_BP      = 46,
  parameter int                 H_PULSE   = 1,
  parameter int                 H_DATA    = 800,
  parameter int                 H_FP      = 294,
  parameter int                 V_BP      = 23,
  parameter int                 V_PULSE   = 5,
  parameter int                 V_DATA    = 480,
  parameter int                 V_FP      = 23,
  parameter bit                 SYNC_POL  = 1'b0,
  parameter int                 COLOR_W   = 16,
  parameter int                 WIN_W     = 64,
  parameter int                 WIN_H     = 64,
  parameter int                 PIX_LAT   = 1,
  parameter logic [COLOR_W-1:0] BG_COLOR  = '0,
  parameter bit                 BORDER_EN = 1'b1
) (
  input  logic                                   clk_pix,
  input  logic                                   reset,
  input  logic [15:0]                            win_x_in,
  input  logic [15:0]                            win_y_in,
  input  logic [15:0]                            line_cmp,
  output logic [15:0]                            pix_x,
  output logic [15:0]                            pix_y,
  output logic                                   pix_valid,
  output logic                                   win_hit,
  output logic [$clog2(WIN_W)+$clog2(WIN_H)-1:0] win_addr,
  input  logic [COLOR_W-1:0]                     pix_in,
  output logic                                   LCD_DEN,
  output logic                                   LCD_HSYNC,
  output logic                                   LCD_VSYNC,
  output logic [COLOR_W-1:0]                     LCD_DATA,
  output logic                                   frame_int,
  output logic                                   line_int
);

  localparam int AW_X = $clog2(WIN_W);
  localparam int AW_Y = $clog2(WIN_H);

  localparam logic [15:0] H_TOT  = 16'(H_BP + H_DATA + H_FP);
  localparam logic [15:0] V_TOT  = 16'(V_BP + V_DATA + V_FP);
  localparam logic [15:0] H_VIS0 = 16'(H_BP);
  localparam logic [15:0] H_VIS1 = 16'(H_BP + H_DATA);
  localparam logic [15:0] V_VIS0 = 16'(V_BP);
  localparam logic [15:0] V_VIS1 = 16'(V_BP + V_DATA);
  localparam logic [15:0] H_PW   = 16'(H_PULSE);
  localparam logic [15:0] V_PW   = 16'(V_PULSE);
  localparam logic [15:0] X_LAST = 16'(H_DATA - 1);
  localparam logic [15:0] Y_LAST = 16'(V_DATA - 1);
  localparam logic [15:0] V_LINES = 16'(V_DATA);
  localparam logic [16:0] V_BP_W  = 17'(V_BP);

  localparam logic signed [16:0] WIN_W_S = 17'(WIN_W);
  localparam logic signed [16:0] WIN_H_S = 17'(WIN_H);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic hit;
    logic edge_px;
  } tap_t;

  // ---------------------------------------------------------------------------
  // Scan counters
  // ---------------------------------------------------------------------------
  logic [15:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic        h_wrap, frame_wrap;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    h_wrap     = (h_cnt == H_TOT - 16'd1);
    frame_wrap = h_wrap && (v_cnt == V_TOT - 16'd1);
    h_nxt      = h_wrap ? 16'd0 : h_cnt + 16'd1;
    v_nxt      = v_cnt;
    if (h_wrap) begin
      v_nxt = frame_wrap ? 16'd0 : v_cnt + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: request to the pixel source
  // ---------------------------------------------------------------------------
  logic visible, hsync_raw, vsync_raw, edge_px;

  always_comb begin
    visible   = (h_cnt >= H_VIS0) && (h_cnt < H_VIS1) &&
                (v_cnt >= V_VIS0) && (v_cnt < V_VIS1);
    pix_x     = visible ? h_cnt - H_VIS0 : 16'd0;
    pix_y     = visible ? v_cnt - V_VIS0 : 16'd0;
    pix_valid = visible;
    hsync_raw = (h_cnt < H_PW);
    vsync_raw = (v_cnt < V_PW);
    edge_px   = visible && ((pix_x == 16'd0) || (pix_y == 16'd0) ||
                            (pix_x == X_LAST) || (pix_y == Y_LAST));
  end

  // Window offsets only take effect at frame boundaries to avoid tearing.
  logic [15:0] wx_q, wy_q;

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      wx_q <= '0;
      wy_q <= '0;
    end else if (frame_wrap) begin
      wx_q <= win_x_in;
      wy_q <= win_y_in;
    end
  end

  // 17-bit signed compares keep offsets near 16'h7FFF from wrapping into view.
  logic signed [16:0] x_s, y_s, wx_s, wy_s;
  logic [AW_X-1:0]    dx;
  logic [AW_Y-1:0]    dy;

  always_comb begin
    x_s     = $signed({1'b0, pix_x});
    y_s     = $signed({1'b0, pix_y});
    wx_s    = $signed({wx_q[15], wx_q});
    wy_s    = $signed({wy_q[15], wy_q});
    dx      = pix_x[AW_X-1:0] - wx_q[AW_X-1:0];
    dy      = pix_y[AW_Y-1:0] - wy_q[AW_Y-1:0];
    win_hit = visible &&
              (x_s >= wx_s) && (x_s < wx_s + WIN_W_S) &&
              (y_s >= wy_s) && (y_s < wy_s + WIN_H_S);
    win_addr = win_hit ? {dy, dx} : '0;
  end

  // ---------------------------------------------------------------------------
  // Interrupts, timed to coincide with the counter state they describe
  // ---------------------------------------------------------------------------
  logic        line_hit;
  logic [16:0] line_tgt;

  always_comb begin
    line_tgt = V_BP_W + {1'b0, line_cmp};
    line_hit = (line_cmp < V_LINES) && (h_nxt == 16'd0) &&
               ({1'b0, v_nxt} == line_tgt);
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      frame_int <= 1'b0;
      line_int  <= 1'b0;
    end else begin
      frame_int <= frame_wrap;
      line_int  <= line_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment delay line, matched to the pixel source latency
  // ---------------------------------------------------------------------------
  tap_t tap_s0, tap_al;

  assign tap_s0 = {visible, hsync_raw, vsync_raw, win_hit, edge_px};

  generate
    if (PIX_LAT == 0) begin : g_no_dly
      assign tap_al = tap_s0;
    end else begin : g_dly
      tap_t dly_q [PIX_LAT];

      // NOTE: this array is a flop chain, not a RAM, so it is reset; otherwise
      // stale sync/DEN bits would reach the pins right after reset release.
      always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIX_LAT; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= tap_s0;
          for (int i = 1; i < PIX_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign tap_al = dly_q[PIX_LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Panel output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      LCD_DEN   <= 1'b0;
      LCD_HSYNC <= ~SYNC_POL;
      LCD_VSYNC <= ~SYNC_POL;
      LCD_DATA  <= '0;
    end else begin
      LCD_DEN   <= tap_al.vis;
      LCD_HSYNC <= tap_al.hs ? SYNC_POL : ~SYNC_POL;
      LCD_VSYNC <= tap_al.vs ? SYNC_POL : ~SYNC_POL;
      if (!tap_al.vis) begin
        LCD_DATA <= '0;
      end else if (BORDER_EN && tap_al.edge_px) begin
        LCD_DATA <= '1;
      end else if (tap_al.hit) begin
        LCD_DATA <= pix_in;
      end else begin
        LCD_DATA <= BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_pipe.sv
// Self-checking bench for lcd_timing_pipe: small-panel configuration, random
// stimulus against a frame-arithmetic reference model, plus window vectors.
module tb_lcd_timing_pipe;

  localparam int HB = 2, HP = 1, HD = 4, HF = 2;
  localparam int VB = 1, VP = 1, VD = 3, VF = 1;
  localparam int HT = HB + HD + HF;
  localparam int VT = VB + VD + VF;
  localparam int FT = HT * VT;
  localparam int LAT = 2;
  localparam int WW = 2, WH = 2;
  localparam logic [15:0] BG = 16'h1E1E;
  localparam int HMAX = 16384;

  logic        clk_pix = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] win_x_in = '0, win_y_in = '0, line_cmp = 16'd2;
  logic [15:0] pix_in = '0;
  logic [15:0] pix_x, pix_y;
  logic        pix_valid, win_hit;
  logic [1:0]  win_addr;
  logic        LCD_DEN, LCD_HSYNC, LCD_VSYNC;
  logic [15:0] LCD_DATA;
  logic        frame_int, line_int;

  lcd_timing_pipe #(
    .H_BP(HB), .H_PULSE(HP), .H_DATA(HD), .H_FP(HF),
    .V_BP(VB), .V_PULSE(VP), .V_DATA(VD), .V_FP(VF),
    .SYNC_POL(1'b0), .COLOR_W(16), .WIN_W(WW), .WIN_H(WH),
    .PIX_LAT(LAT), .BG_COLOR(BG), .BORDER_EN(1'b0)
  ) dut (
    .clk_pix(clk_pix), .reset(reset),
    .win_x_in(win_x_in), .win_y_in(win_y_in), .line_cmp(line_cmp),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .win_hit(win_hit), .win_addr(win_addr), .pix_in(pix_in),
    .LCD_DEN(LCD_DEN), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC),
    .LCD_DATA(LCD_DATA), .frame_int(frame_int), .line_int(line_int)
  );

  always #5 clk_pix = ~clk_pix;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: where is the scan at clock n, and what should be there.
  typedef struct {
    bit vis, hs, vs, hit, edge_px;
    int x, y, addr;
  } pix_t;

  function automatic pix_t model(int n, logic [15:0] wx, logic [15:0] wy);
    pix_t p;
    int h, v, sx, sy;
    h  = n % HT;
    v  = (n / HT) % VT;
    sx = int'($signed(wx));
    sy = int'($signed(wy));
    p.vis = (h >= HB) && (h < HB + HD) && (v >= VB) && (v < VB + VD);
    p.x   = p.vis ? h - HB : 0;
    p.y   = p.vis ? v - VB : 0;
    p.hs  = (h < HP);
    p.vs  = (v < VP);
    p.hit = p.vis && (p.x >= sx) && (p.x < sx + WW) && (p.y >= sy) && (p.y < sy + WH);
    p.addr = p.hit ? (p.y - sy) * WW + (p.x - sx) : 0;
    p.edge_px = p.vis && (p.x == 0 || p.y == 0 || p.x == HD - 1 || p.y == VD - 1);
    return p;
  endfunction

  int n = 0;
  int n_checks = 0, n_fail = 0;
  logic [15:0] pix_h [HMAX];
  logic [15:0] lc_h  [HMAX];
  logic [15:0] wx_h  [HMAX];
  logic [15:0] wy_h  [HMAX];
  logic [15:0] wx_m = '0, wy_m = '0;
  bit rand_win = 0, rand_lc = 0, pix_a5 = 0;
  int den_cnt = 0, hs_low = 0, vs_low = 0, line_cnt = 0, last_fi = -1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (clock %0d)", name, act, exp, n);
    end
  endtask

  task automatic drive();
    pix_in = pix_a5 ? 16'hA5A5 : 16'($urandom);
    if (rand_win && $urandom_range(0, 19) == 0) win_x_in = 16'($urandom_range(0, 8)) - 16'd3;
    if (rand_win && $urandom_range(0, 19) == 0) win_y_in = 16'($urandom_range(0, 6)) - 16'd3;
    if (rand_lc && $urandom_range(0, 29) == 0) line_cmp = 16'($urandom_range(0, 4));
    pix_h[n] = pix_in;
    lc_h[n]  = line_cmp;
  endtask

  task automatic check_all();
    pix_t s, d;
    logic [15:0] exp_data;
    int h, v, lc;
    s = model(n, wx_h[n], wy_h[n]);
    check("pix_x", pix_x, s.x);
    check("pix_y", pix_y, s.y);
    check("pix_valid", pix_valid, s.vis);
    check("win_hit", win_hit, s.hit);
    check("win_addr", win_addr, s.addr);
    h  = n % HT;
    v  = (n / HT) % VT;
    lc = (n > 0) ? int'(lc_h[n-1]) : 0;
    check("frame_int", frame_int, (n > 0) && (n % FT == 0));
    check("line_int", line_int, (n > 0) && (h == 0) && (lc < VD) && (v == VB + lc));
    if (n < LAT + 1) begin
      check("LCD_DEN_rst", LCD_DEN, 0);
      check("LCD_HSYNC_rst", LCD_HSYNC, 1);
      check("LCD_VSYNC_rst", LCD_VSYNC, 1);
      check("LCD_DATA_rst", LCD_DATA, 0);
    end else begin
      d = model(n - LAT - 1, wx_h[n-LAT-1], wy_h[n-LAT-1]);
      if (!d.vis) exp_data = 16'h0000;
      else if (d.hit) exp_data = pix_h[n-1];
      else exp_data = BG;
      check("LCD_DEN", LCD_DEN, d.vis);
      check("LCD_HSYNC", LCD_HSYNC, d.hs ? 0 : 1);
      check("LCD_VSYNC", LCD_VSYNC, d.vs ? 0 : 1);
      check("LCD_DATA", LCD_DATA, exp_data);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
    if (n >= HMAX - 2) begin
      $display("FAIL history: clock index %0d, required below %0d", n, HMAX - 2);
      $fatal(1, "history overflow");
    end
    if (n % FT == FT - 1) begin
      wx_m = win_x_in;
      wy_m = win_y_in;
    end
    n++;
    wx_h[n] = wx_m;
    wy_h[n] = wy_m;
    check_all();
    if (LCD_DEN) den_cnt++;
    if (!LCD_HSYNC) hs_low++;
    if (!LCD_VSYNC) vs_low++;
    if (line_int) line_cnt++;
    if (frame_int) begin
      if (last_fi < 0) check("first_frame_int", n, FT);
      else check("frame_int_period", n - last_fi, FT);
      last_fi = n;
    end
    drive();
  endtask

  task automatic goto_px(int x, int y);
    do tick(); while (!((n % HT) == x + HB && ((n / HT) % VT) == y + VB));
  endtask

  task automatic goto_wrap();
    do tick(); while (n % FT != 0);
  endtask

  task automatic restart_model();
    n = 0;
    wx_m = '0;
    wy_m = '0;
    wx_h[0] = '0;
    wy_h[0] = '0;
    last_fi = -1;
    drive();
  endtask

  task automatic measure_start();
    int k = 0;
    while (!LCD_DEN && k < 100) begin
      tick();
      k++;
    end
    check("first_den_rise", n, 13);
    den_cnt = 0; hs_low = 0; vs_low = 0;
    repeat (FT) tick();
    check("den_per_frame", den_cnt, VD * HD);
    check("hsync_low_per_frame", hs_low, VT * HP);
    check("vsync_low_per_frame", vs_low, VP * HT);
  endtask

  typedef struct {
    logic [15:0] wx, wy;
    int x, y;
    bit hit;
    logic [1:0] addr;
  } win_vec_t;

  win_vec_t vt [16];

  initial begin
    vt[0]  = '{16'd1,    16'd1,    1, 1, 1'b1, 2'd0};
    vt[1]  = '{16'd1,    16'd1,    2, 1, 1'b1, 2'd1};
    vt[2]  = '{16'd1,    16'd1,    1, 2, 1'b1, 2'd2};
    vt[3]  = '{16'd1,    16'd1,    2, 2, 1'b1, 2'd3};
    vt[4]  = '{16'd1,    16'd1,    0, 1, 1'b0, 2'd0};
    vt[5]  = '{16'd1,    16'd1,    3, 2, 1'b0, 2'd0};
    vt[6]  = '{16'd1,    16'd1,    1, 0, 1'b0, 2'd0};
    vt[7]  = '{16'hFFFF, 16'd0,    0, 0, 1'b1, 2'd1};
    vt[8]  = '{16'hFFFF, 16'd0,    0, 1, 1'b1, 2'd3};
    vt[9]  = '{16'hFFFF, 16'd0,    1, 0, 1'b0, 2'd0};
    vt[10] = '{16'h7FFF, 16'd0,    0, 0, 1'b0, 2'd0};
    vt[11] = '{16'h7FFF, 16'd0,    3, 2, 1'b0, 2'd0};
    vt[12] = '{16'd0,    16'hFFFF, 0, 0, 1'b1, 2'd2};
    vt[13] = '{16'd0,    16'hFFFF, 0, 1, 1'b0, 2'd0};
    vt[14] = '{16'd2,    16'd1,    3, 2, 1'b1, 2'd3};
    vt[15] = '{16'd2,    16'd1,    2, 1, 1'b1, 2'd0};

    // Power-up reset and start-of-scan timing.
    reset = 1'b1;
    restart_model();
    repeat (3) @(negedge clk_pix);
    check_all();
    reset = 1'b0;
    measure_start();

    // Random offsets, line compare and pixel data against the model.
    rand_win = 1; rand_lc = 1;
    repeat (40 * FT) tick();
    rand_win = 0; rand_lc = 0;

    // Window vectors with a constant source pattern.
    pix_a5 = 1;
    for (int i = 0; i < 16; i++) begin
      win_x_in = vt[i].wx;
      win_y_in = vt[i].wy;
      goto_wrap();
      goto_px(vt[i].x, vt[i].y);
      check("tbl_win_hit", win_hit, vt[i].hit);
      check("tbl_win_addr", win_addr, vt[i].addr);
      repeat (LAT + 1) tick();
      check("tbl_lcd_data", LCD_DATA, vt[i].hit ? 16'hA5A5 : BG);
    end

    // Mid-frame offset change waits for the frame wrap.
    win_x_in = 16'd1; win_y_in = 16'd1;
    goto_wrap();
    goto_px(1, 1);
    check("mid_hit_before", win_hit, 1);
    check("mid_addr_before", win_addr, 0);
    win_x_in = 16'd0;
    goto_px(2, 2);
    check("mid_hit_same_frame", win_hit, 1);
    check("mid_addr_same_frame", win_addr, 3);
    goto_wrap();
    goto_px(0, 1);
    check("mid_hit_next_frame", win_hit, 1);
    check("mid_addr_next_frame", win_addr, 0);
    goto_px(2, 1);
    check("mid_nohit_next_frame", win_hit, 0);
    pix_a5 = 0;

    // Line interrupt: one pulse for a visible line, none past the last line.
    line_cmp = 16'd2;
    goto_wrap();
    line_cnt = 0;
    repeat (FT) tick();
    check("line_int_count_cmp2", line_cnt, 1);
    line_cmp = 16'd3;
    goto_wrap();
    line_cnt = 0;
    repeat (2 * FT) tick();
    check("line_int_count_cmp3", line_cnt, 0);

    // Asynchronous reset mid-line, then a clean restart.
    win_x_in = 16'd1; win_y_in = 16'd0;
    goto_wrap();
    goto_px(1, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_den", LCD_DEN, 0);
    check("rst_hsync", LCD_HSYNC, 1);
    check("rst_vsync", LCD_VSYNC, 1);
    check("rst_data", LCD_DATA, 0);
    check("rst_frame_int", frame_int, 0);
    check("rst_line_int", line_int, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_win_hit", win_hit, 0);
    restart_model();
    @(negedge clk_pix);
    reset = 1'b0;
    measure_start();
    rand_win = 1; rand_lc = 1;
    repeat (10 * FT) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_timing_pipe.md
Name: lcd_timing_pipe

Overview:
- Parametrised successor of the fixed 800x480 RGB565 LCD scan generator.
- Generates HSYNC, VSYNC and DEN from parameterised porch and pulse timings, with selectable sync polarity.
- Issues a per-pixel request (coordinates plus sprite-window hit and address) to an external pixel source with fixed read latency, and re-aligns sync and DEN to the returned data.
- Sits between the system bus (offset, line-compare inputs and interrupts) and the panel pins.

Parameters:
H_BP, 46, horizontal back porch (clocks, counted from line start, includes pulse)
H_PULSE, 1, HSYNC active width (clocks)
H_DATA, 800, visible pixels per line
H_FP, 294, horizontal front porch
V_BP, 23, vertical back porch (lines, includes pulse)
V_PULSE, 5, VSYNC active width (lines)
V_DATA, 480, visible lines
V_FP, 23, vertical front porch
SYNC_POL, 0, 0 = syncs active-low, 1 = active-high
COLOR_W, 16, pixel data width
WIN_W, 64, sprite window width (power of 2)
WIN_H, 64, sprite window height (power of 2)
PIX_LAT, 1, pixel source read latency in clocks (0..7)
BG_COLOR, 16'h0000, colour output when DEN is high and the pixel is outside the window
BORDER_EN, 1, 1 = force all-ones on visible edge pixels

Ports:
clk_pix  in  1  pixel clock
reset  in  1  asynchronous active-high reset
win_x_in  in  16  signed window X offset (visible coordinates)
win_y_in  in  16  signed window Y offset
line_cmp  in  16  visible line number that raises line_int
pix_x  out  16  visible X at stage 0, 0 when not visible
pix_y  out  16  visible Y at stage 0, 0 when not visible
pix_valid  out  1  stage-0 pixel is visible
win_hit  out  1  stage-0 pixel lies inside the window
win_addr  out  log2(WIN_W)+log2(WIN_H)  {y-wy, x-wx}, 0 when no hit
pix_in  in  COLOR_W  source data for the request made PIX_LAT clocks earlier
LCD_DEN  out  1  data enable, aligned to LCD_DATA
LCD_HSYNC  out  1  horizontal sync, aligned
LCD_VSYNC  out  1  vertical sync, aligned
LCD_DATA  out  COLOR_W  pixel colour
frame_int  out  1  one-clock pulse at frame wrap
line_int  out  1  one-clock pulse at start of line line_cmp

Behaviour:
- Totals: H_TOT = H_BP+H_DATA+H_FP; V_TOT = V_BP+V_DATA+V_FP.
- Counters: h runs 0..H_TOT-1. When h wraps, v increments and runs 0..V_TOT-1. No extra terminal states.
- Stage 0 signals are combinational from the registered h and v:
  - visible = h in [H_BP, H_BP+H_DATA) and v in [V_BP, V_BP+V_DATA).
  - pix_x = h-H_BP and pix_y = v-V_BP when visible, else 0.
  - hsync_raw is active when h<H_PULSE; vsync_raw is active when v<V_PULSE.
- Window hit: compare in 17-bit signed arithmetic so no overflow occurs. win_hit = visible and x>=wx and x<wx+WIN_W and y>=wy and y<wy+WIN_H.
- Window offsets wx and wy come from shadow registers. The shadows load win_x_in and win_y_in only on the frame-wrap clock (h=H_TOT-1 and v=V_TOT-1). Mid-frame changes therefore have no effect until the next frame.
- Alignment pipeline:
  - visible, hsync_raw, vsync_raw, win_hit and the border flag are delayed PIX_LAT clocks.
  - At that point pix_in is valid. One output register stage follows.
  - Total latency from counter state to pins is PIX_LAT+1 clocks.
- LCD_DATA register selection, in priority order:
  1. not visible: 0
  2. BORDER_EN and edge pixel (x=0, y=0, x=H_DATA-1 or y=V_DATA-1): all ones
  3. win_hit: pix_in
  4. otherwise: BG_COLOR
- Sync output level = SYNC_POL when active, otherwise ~SYNC_POL.
- frame_int is registered and high for exactly one clock: the clock in which the counters read (0,0) after a wrap. It is not raised after reset.
- line_int is registered and high for one clock when h=0 and v=V_BP+line_cmp. It is never raised if line_cmp>=V_DATA.
- Reset, asynchronous, at any time including mid-frame:
  - h, v, shadows and the entire delay line clear to 0.
  - LCD_DEN, LCD_DATA, frame_int and line_int go to 0.
  - Syncs go to their inactive level.
  - After release, scanning restarts at (0,0).

Test Plan:
All scenarios use a bench configuration of H_BP=2, H_PULSE=1, H_DATA=4, H_FP=2 (H_TOT=8); V_BP=1, V_PULSE=1, V_DATA=3, V_FP=1 (V_TOT=6); PIX_LAT=2; WIN_W=WIN_H=2; SYNC_POL=0; BORDER_EN=0.
1. Release reset and count clocks -> first LCD_DEN rise 13 clocks after the first active edge. DEN is high for 4 clocks per line on 3 lines. HSYNC is low for 1 clock every 8. VSYNC is low for 8 clocks every 48.
2. Run multiple frames -> frame_int pulses exactly every 48 clocks, with no pulse at the first (0,0) after reset.
3. Set win_x_in=1 and win_y_in=1, with the source returning pix_in = 16'hA5A5 on requests. After the first frame wrap -> win_hit is asserted at visible (1,1), (2,1), (1,2) and (2,2) with win_addr 0, 1, 2, 3. LCD_DATA is A5A5 at those pixels and BG_COLOR elsewhere.
4. Change win_x_in mid-frame -> hit positions are unchanged until the next frame wrap, then shift.
5. Set win_x_in=-1 (16'hFFFF) -> only x=0 hits, with win_addr low bit 1. Set win_x_in=16'h7FFF -> no hit and no wrap artefact.
6. Set line_cmp=2 -> line_int pulses when v=3 and h=0. Set line_cmp=3 -> line_int never pulses. Assert reset mid-line -> all outputs take their reset values immediately, and the restart matches scenario 1.
